// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// N independent button/switch conditioning channels. Each channel brings a raw
// asynchronous input into the clock domain through a 2-flop synchroniser. A
// stability counter then debounces it. The channel emits a clean level,
// one-cycle press/release pulses and a one-shot long-press pulse.
//
// Parameters:
//   N            - number of channels (>= 1)
//   BOUNCE_TICKS - consecutive synchronised cycles a new value must hold (>= 1)
//   HOLD_TICKS   - cycles of debounced high before long_press fires (0 = off)
//
// Ports:
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   bouncy_in     in   N   raw asynchronous inputs, active-high
//   debounced_out out  N   clean registered level per channel
//   rise          out  N   one-cycle pulse on debounced 0->1
//   fall          out  N   one-cycle pulse on debounced 1->0
//   long_press    out  N   one-cycle pulse after HOLD_TICKS cycles high
// -----------------------------------------------------------------------------
module debounce_bank #(
    parameter int N            = 2,
    parameter int BOUNCE_TICKS = 4,
    parameter int HOLD_TICKS   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] bouncy_in,
    output logic [N-1:0] debounced_out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long_press
);

    localparam int BW = $clog2(BOUNCE_TICKS + 1);
    localparam logic [BW-1:0] B_LAST = BW'(BOUNCE_TICKS - 1);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          sync1_r;
        logic          sync2_r;
        logic [BW-1:0] bcnt_r;
        logic          deb_r;
        logic          rise_r;
        logic          fall_r;
        logic          mismatch_s;
        logic          flip_s;

        // Accept a new level once the mismatch has lasted BOUNCE_TICKS cycles.
        always_comb begin
            mismatch_s = (sync2_r != deb_r);
            flip_s     = mismatch_s && (bcnt_r == B_LAST);
        end

        // Two-flop synchroniser for the raw asynchronous input.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
            end else begin
                sync1_r <= bouncy_in[i];
                sync2_r <= sync1_r;
            end
        end

        // Stability counter, debounced level and edge pulses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bcnt_r <= {BW{1'b0}};
                deb_r  <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                // Pulses are decoded from the pre-toggle level so they line up
                // with the first cycle the new level is visible.
                rise_r <= flip_s && !deb_r;
                fall_r <= flip_s && deb_r;
                if (!mismatch_s) begin
                    bcnt_r <= {BW{1'b0}};
                end else if (flip_s) begin
                    deb_r  <= !deb_r;
                    bcnt_r <= {BW{1'b0}};
                end else begin
                    bcnt_r <= bcnt_r + BW'(1);
                end
            end
        end

        assign debounced_out[i] = deb_r;
        assign rise[i]          = rise_r;
        assign fall[i]          = fall_r;

        if (HOLD_TICKS > 0) begin : g_hold
            localparam int HW = $clog2(HOLD_TICKS + 1);
            localparam logic [HW-1:0] H_MAX  = HW'(HOLD_TICKS);
            localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);

            logic [HW-1:0] hcnt_r;
            logic          lp_r;

            // Saturating hold counter. It only re-arms through a debounced
            // release, so long_press fires at most once per press.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hcnt_r <= {HW{1'b0}};
                    lp_r   <= 1'b0;
                end else if (!deb_r) begin
                    hcnt_r <= {HW{1'b0}};
                    lp_r   <= 1'b0;
                end else if (hcnt_r != H_MAX) begin
                    hcnt_r <= hcnt_r + HW'(1);
                    lp_r   <= (hcnt_r == H_LAST);
                end else begin
                    lp_r   <= 1'b0;
                end
            end

            assign long_press[i] = lp_r;
        end else begin : g_no_hold
            assign long_press[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
//
// Directed bench for debounce_bank with default parameters (N=2,
// BOUNCE_TICKS=4, HOLD_TICKS=64). Inputs change on the falling edge and
// outputs are checked on the falling edge. Pulse counters are kept by
// monitors that sample shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

    logic       clk;
    logic       rst;
    logic [1:0] bouncy_in;
    logic [1:0] debounced_out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] long_press;

    int n_vec;
    int n_err;
    int rise_cnt [2];
    int fall_cnt [2];
    int lp_cnt   [2];

    debounce_bank #(.N(2), .BOUNCE_TICKS(4), .HOLD_TICKS(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .bouncy_in     (bouncy_in),
        .debounced_out (debounced_out),
        .rise          (rise),
        .fall          (fall),
        .long_press    (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        for (int c = 0; c < 2; c++) begin
            if (rise[c])       rise_cnt[c]++;
            if (fall[c])       fall_cnt[c]++;
            if (long_press[c]) lp_cnt[c]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int n_tog;
        n_vec = 0;
        n_err = 0;
        for (int c = 0; c < 2; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            lp_cnt[c]   = 0;
        end
        rst       = 1'b1;
        bouncy_in = 2'b00;

        // 1. Reset
        @(negedge clk);
        step(2);
        check("reset_outputs", {debounced_out, rise, fall, long_press}, 32'h0);
        rst = 1'b0;
        step(3);
        check("post_reset_idle", {debounced_out, rise, fall, long_press}, 32'h0);

        // 2. Clean press on channel 1, edge k is the next rising edge
        bouncy_in = 2'b10;
        step(5);
        check("press_k4_deb", {30'd0, debounced_out}, 32'h0);
        step(1);
        check("press_k5_deb", {30'd0, debounced_out}, 32'h2);
        check("press_k5_rise", {30'd0, rise}, 32'h2);
        step(1);
        check("press_k6_rise", {30'd0, rise}, 32'h0);
        step(62);
        check("press_k68_lp", {30'd0, long_press}, 32'h0);
        step(1);
        check("press_k69_lp", {30'd0, long_press}, 32'h2);
        step(1);
        check("press_k70_lp", {30'd0, long_press}, 32'h0);
        step(20);
        check("press_lp_once", lp_cnt[1], 32'd1);
        check("press_rise_once", rise_cnt[1], 32'd1);
        bouncy_in = 2'b00;
        step(6);
        check("release_deb", {30'd0, debounced_out}, 32'h0);
        check("release_fall", {30'd0, fall}, 32'h2);

        // 3. Bounce rejection on channel 0 (high bursts of at most 3 cycles)
        n_tog = $urandom_range(30, 10);
        for (int t = 0; t < n_tog; t++) begin
            bouncy_in[0] = ~bouncy_in[0];
            step($urandom_range(3, 1));
        end
        bouncy_in[0] = 1'b0;
        step(3);
        check("bounce_no_rise", rise_cnt[0], 32'd0);
        bouncy_in[0] = 1'b1;
        step(5);
        check("bounce_k4_deb", {30'd0, debounced_out}, 32'h0);
        step(1);
        check("bounce_k5_deb", {30'd0, debounced_out}, 32'h1);
        check("bounce_k5_rise", {30'd0, rise}, 32'h1);
        check("bounce_rise_once", rise_cnt[0], 32'd1);
        check("bounce_no_fall", fall_cnt[0], 32'd0);

        // 4. Short press: input high for 20 sampled edges, k..k+19
        step(14);
        bouncy_in[0] = 1'b0;
        step(5);
        check("short_k24_fall", {30'd0, fall}, 32'h0);
        step(1);
        check("short_k25_fall", {30'd0, fall}, 32'h1);
        check("short_k25_deb", {30'd0, debounced_out}, 32'h0);
        step(10);
        check("short_no_lp", lp_cnt[0], 32'd0);

        // 5. Simultaneous channels
        bouncy_in = 2'b11;
        step(6);
        check("simul_rise", {30'd0, rise}, 32'h3);
        check("simul_deb", {30'd0, debounced_out}, 32'h3);
        bouncy_in = 2'b10;
        step(6);
        check("simul_fall", {30'd0, fall}, 32'h1);
        check("simul_deb2", {30'd0, debounced_out}, 32'h2);

        // 6. Asynchronous reset 30 cycles into channel 1's hold
        step(24);
        #1 rst = 1'b1;
        #1 check("async_rst_clear", {debounced_out, rise, fall, long_press}, 32'h0);
        @(negedge clk);
        step(2);
        check("rst_no_fall", fall_cnt[1], 32'd1);
        rst = 1'b0;
        step(5);
        check("rerise_k4_deb", {30'd0, debounced_out}, 32'h0);
        step(1);
        check("rerise_k5_deb", {30'd0, debounced_out}, 32'h2);
        check("rerise_k5_rise", {30'd0, rise}, 32'h2);
        step(63);
        check("rerise_k68_lp", {30'd0, long_press}, 32'h0);
        step(1);
        check("rerise_k69_lp", {30'd0, long_press}, 32'h2);
        step(3);
        check("final_lp1", lp_cnt[1], 32'd2);
        check("final_lp0", lp_cnt[0], 32'd0);
        check("final_rise1", rise_cnt[1], 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
